// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: register map, bit
// positions, config FSM encoding and FIFO entry layout.
package uart_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ERR_W  = 3;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_ERRSTAT = 2'd3;

    localparam int unsigned CTRL_IE_RX  = 5;
    localparam int unsigned CTRL_IE_ERR = 6;
    localparam int unsigned CTRL_FLUSH  = 7;

    localparam int unsigned ERRSTAT_OVR = 3;
    localparam int unsigned ERRSTAT_TAG = 4;

    localparam int unsigned RXERR_PARITY = 0;
    localparam int unsigned RXERR_START  = 1;
    localparam int unsigned RXERR_STOP   = 2;

    typedef enum logic [1:0] {
        IDLE_CFG = 2'd0,
        APPLIED  = 2'd1,
        PENDING  = 2'd2
    } cfg_state_e;

    // Field order matches CTRL[4:0]
    typedef struct packed {
        logic [1:0] baud;
        logic [1:0] parity;
        logic       en;
    } cfg_t;

    typedef struct packed {
        logic              tag;
        logic [DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous FIFO of received bytes with error tag; flush dominates push,
// a pop on a full FIFO makes room for a same-cycle push.
module rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  rx_entry_t     wdata,
    output rx_entry_t     head_c,
    output logic [CW-1:0] count,
    output logic          full_c,
    output logic          empty_c,
    output logic          overrun_c
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    rx_entry_t     mem [DEPTH];
    logic          do_push_c;
    logic          do_pop_c;

    assign empty_c   = (count == '0);
    assign full_c    = (count == CW'(DEPTH));
    assign do_pop_c  = pop & ~empty_c & ~flush;
    assign do_push_c = push & ~flush & (~full_c | do_pop_c);
    assign overrun_c = push & full_c & ~pop & ~flush;
    assign head_c    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push_c) - CW'(do_pop_c);
        end
    end

    // Storage is not reset; entries are only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Bus-facing controller for the UART receiver: staged config apply between
// frames, byte capture into a FIFO, sticky error status and interrupt.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter logic [7:0]  CTRL_RST = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_active,
    input  logic              rx_done,
    input  logic [ERR_W-1:0]  rx_error,
    input  logic [DATA_W-1:0] rx_data,
    output logic [1:0]        cfg_parity_type,
    output logic [1:0]        cfg_baud_rate,
    output logic              rx_enable,
    input  logic              bus_sel,
    input  logic              bus_we,
    input  logic [1:0]        bus_addr,
    input  logic [7:0]        bus_wdata,
    output logic [7:0]        bus_rdata,
    output logic              irq
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    cfg_state_e    state_q, state_d;
    cfg_t          shadow_q, cfg_q;
    logic          ie_rx_q, ie_err_q;
    logic          rx_done_q;
    logic [3:0]    errstat_q;
    logic          apply_c;
    logic          rd_c, wr_c, ctrl_wr_c, flush_c, pop_c, push_c;
    logic [3:0]    err_set_c, err_clr_c;
    logic [7:0]    rdata_c;
    rx_entry_t     head_c;
    logic [CW-1:0] count;
    logic          full_c, empty_c, overrun_c, head_tag_c;

    assign rd_c      = bus_sel & ~bus_we;
    assign wr_c      = bus_sel & bus_we;
    assign ctrl_wr_c = wr_c & (bus_addr == ADDR_CTRL);
    assign flush_c   = ctrl_wr_c & bus_wdata[CTRL_FLUSH];
    assign pop_c     = rd_c & (bus_addr == ADDR_DATA);
    assign push_c    = rx_done & ~rx_done_q & cfg_q.en;

    rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .pop       (pop_c),
        .flush     (flush_c),
        .wdata     ({|rx_error, rx_data}),
        .head_c    (head_c),
        .count     (count),
        .full_c    (full_c),
        .empty_c   (empty_c),
        .overrun_c (overrun_c)
    );

    // Config FSM: pending settings wait for an idle receiver; a new write restarts the wait
    always_comb begin
        state_d = state_q;
        apply_c = 1'b0;
        case (state_q)
            IDLE_CFG, APPLIED: begin
                if (ctrl_wr_c) state_d = PENDING;
            end
            PENDING: begin
                if (ctrl_wr_c) begin
                    state_d = PENDING;
                end else if (!rx_active) begin
                    apply_c = 1'b1;
                    state_d = APPLIED;
                end
            end
            default: state_d = IDLE_CFG;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE_CFG;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= cfg_t'(CTRL_RST[4:0]);
            cfg_q    <= cfg_t'(CTRL_RST[4:0]);
            ie_rx_q  <= CTRL_RST[CTRL_IE_RX];
            ie_err_q <= CTRL_RST[CTRL_IE_ERR];
        end else begin
            if (ctrl_wr_c) begin
                shadow_q <= cfg_t'(bus_wdata[4:0]);
                ie_rx_q  <= bus_wdata[CTRL_IE_RX];
                ie_err_q <= bus_wdata[CTRL_IE_ERR];
            end
            if (apply_c) cfg_q <= shadow_q;
        end
    end

    assign cfg_parity_type = cfg_q.parity;
    assign cfg_baud_rate   = cfg_q.baud;
    assign rx_enable       = cfg_q.en;

    // Set beats a same-cycle write-1-to-clear
    assign err_set_c = {overrun_c,
                        push_c & rx_error[RXERR_STOP],
                        push_c & rx_error[RXERR_START],
                        push_c & rx_error[RXERR_PARITY]};
    assign err_clr_c = (wr_c && bus_addr == ADDR_ERRSTAT) ? bus_wdata[3:0] : 4'h0;
    assign head_tag_c = ~empty_c & head_c.tag;

    always_comb begin
        rdata_c = 8'h00;
        case (bus_addr)
            ADDR_DATA:    rdata_c = empty_c ? 8'h00 : head_c.data;
            ADDR_STATUS:  rdata_c = {(state_q == PENDING), rx_active, full_c, empty_c, 4'(count)};
            ADDR_CTRL:    rdata_c = {1'b0, ie_err_q, ie_rx_q, shadow_q};
            ADDR_ERRSTAT: begin
                rdata_c[ERRSTAT_OVR:0] = errstat_q;
                rdata_c[ERRSTAT_TAG]   = head_tag_c;
            end
            default:      rdata_c = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_done_q <= 1'b0;
            errstat_q <= 4'h0;
            bus_rdata <= 8'h00;
            irq       <= 1'b0;
        end else begin
            rx_done_q <= rx_done;
            errstat_q <= (errstat_q & ~err_clr_c) | err_set_c;
            if (rd_c) bus_rdata <= rdata_c;
            irq <= (ie_rx_q & ~empty_c) | (ie_err_q & (|errstat_q));
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue-based reference model checked every cycle,
// plus directed register reads with hand-computed values.
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH    = 8;
    localparam logic [7:0]  CTRL_RST = 8'h01;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_active = 1'b0;
    logic       rx_done = 1'b0;
    logic [2:0] rx_error = 3'b000;
    logic [7:0] rx_data = 8'h00;
    logic       bus_sel = 1'b0;
    logic       bus_we = 1'b0;
    logic [1:0] bus_addr = 2'd0;
    logic [7:0] bus_wdata = 8'h00;
    logic [1:0] cfg_parity_type;
    logic [1:0] cfg_baud_rate;
    logic       rx_enable;
    logic [7:0] bus_rdata;
    logic       irq;

    int total = 0;
    int bad = 0;

    uart_rx_ctrl #(.DEPTH(DEPTH), .CTRL_RST(CTRL_RST)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_active       (rx_active),
        .rx_done         (rx_done),
        .rx_error        (rx_error),
        .rx_data         (rx_data),
        .cfg_parity_type (cfg_parity_type),
        .cfg_baud_rate   (cfg_baud_rate),
        .rx_enable       (rx_enable),
        .bus_sel         (bus_sel),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_rdata       (bus_rdata),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, registers as plain variables
    logic [8:0] mq[$];
    logic [3:0] m_err;
    logic       m_ie_rx, m_ie_err, m_pend, m_done_prev, m_irq;
    logic [4:0] m_sh, m_cfg;
    logic [7:0] m_rdata;

    always @(posedge clk or negedge reset) begin : model
        int n;
        logic rd, wr, cap, pop, flush, ovr, nirq;
        logic [3:0] clr;
        if (!reset) begin
            mq.delete();
            m_err = 4'h0;
            m_ie_rx = CTRL_RST[5];
            m_ie_err = CTRL_RST[6];
            m_sh = CTRL_RST[4:0];
            m_cfg = CTRL_RST[4:0];
            m_pend = 1'b0;
            m_done_prev = 1'b0;
            m_rdata = 8'h00;
            m_irq = 1'b0;
        end else begin
            n = mq.size();
            nirq = (m_ie_rx && n != 0) || (m_ie_err && m_err != 4'h0);
            rd = bus_sel && !bus_we;
            wr = bus_sel && bus_we;
            cap = rx_done && !m_done_prev && m_cfg[0];
            if (rd) begin
                case (bus_addr)
                    2'd0:    m_rdata = (n != 0) ? mq[0][7:0] : 8'h00;
                    2'd1:    m_rdata = {m_pend, rx_active, n == DEPTH, n == 0, 4'(n)};
                    2'd2:    m_rdata = {1'b0, m_ie_err, m_ie_rx, m_sh};
                    default: m_rdata = {3'b000, (n != 0) ? mq[0][8] : 1'b0, m_err};
                endcase
            end
            pop = rd && bus_addr == 2'd0 && n != 0;
            flush = wr && bus_addr == 2'd2 && bus_wdata[7];
            ovr = cap && n == DEPTH && !pop && !flush;
            if (flush) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (cap && (n < DEPTH || pop)) mq.push_back({|rx_error, rx_data});
            end
            clr = (wr && bus_addr == 2'd3) ? bus_wdata[3:0] : 4'h0;
            m_err = (m_err & ~clr) | {ovr, cap ? rx_error : 3'b000};
            if (wr && bus_addr == 2'd2) begin
                m_ie_rx = bus_wdata[5];
                m_ie_err = bus_wdata[6];
                m_sh = bus_wdata[4:0];
                m_pend = 1'b1;
            end else if (m_pend && !rx_active) begin
                m_cfg = m_sh;
                m_pend = 1'b0;
            end
            m_done_prev = rx_done;
            m_irq = nirq;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("cfg_parity_type", 8'(cfg_parity_type), 8'(m_cfg[2:1]));
            chk("cfg_baud_rate", 8'(cfg_baud_rate), 8'(m_cfg[4:3]));
            chk("rx_enable", 8'(rx_enable), 8'(m_cfg[0]));
            chk("irq", 8'(irq), 8'(m_irq));
            chk("bus_rdata", bus_rdata, m_rdata);
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(negedge clk);
        bus_sel = 1'b0; bus_we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
        @(negedge clk);
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
        @(negedge clk);
        bus_sel = 1'b0;
        chk(name, bus_rdata, exp);
    endtask

    task automatic capture(input logic [7:0] d, input logic [2:0] e);
        @(negedge clk);
        rx_data = d; rx_error = e; rx_done = 1'b1;
        repeat (3) @(negedge clk);
        rx_done = 1'b0; rx_error = 3'b000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset values
        idle(2);
        chk("rst_baud", 8'(cfg_baud_rate), 8'h00);
        chk("rst_parity", 8'(cfg_parity_type), 8'h00);
        chk("rst_enable", 8'(rx_enable), 8'h01);
        chk("rst_irq", 8'(irq), 8'h00);
        reset = 1'b1;
        rd_chk("rst_status", 2'd1, 8'h10);

        // Single capture, held done, interrupt and pop
        bus_write(2'd2, 8'h21);
        idle(2);
        capture(8'hA5, 3'b000);
        chk("irq_after_push", 8'(irq), 8'h01);
        rd_chk("status_one", 2'd1, 8'h01);
        rd_chk("data_a5", 2'd0, 8'hA5);
        rd_chk("status_empty", 2'd1, 8'h10);
        chk("irq_after_pop", 8'(irq), 8'h00);

        // Config held while a frame is active
        @(negedge clk) rx_active = 1'b1;
        bus_write(2'd2, 8'h31);
        idle(2);
        chk("baud_held", 8'(cfg_baud_rate), 8'h00);
        rd_chk("status_pending", 2'd1, 8'hD0);
        @(negedge clk) rx_active = 1'b0;
        @(negedge clk);
        chk("baud_applied", 8'(cfg_baud_rate), 8'h02);
        rd_chk("status_applied", 2'd1, 8'h10);

        // Fill, overrun, W1C, pop+push when full
        for (int i = 0; i < 9; i++) capture(8'h10 + 8'(i), 3'b000);
        rd_chk("status_full", 2'd1, 8'h28);
        rd_chk("errstat_ovr", 2'd3, 8'h08);
        bus_write(2'd3, 8'h08);
        rd_chk("errstat_clr", 2'd3, 8'h00);
        @(negedge clk);
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 2'd0;
        rx_data = 8'h77; rx_error = 3'b000; rx_done = 1'b1;
        @(negedge clk);
        bus_sel = 1'b0;
        chk("data_full_pop", bus_rdata, 8'h10);
        idle(2);
        rx_done = 1'b0;
        rd_chk("status_still_full", 2'd1, 8'h28);
        rd_chk("errstat_no_ovr", 2'd3, 8'h00);
        bus_write(2'd2, 8'hB1);
        idle(2);
        rd_chk("status_flushed", 2'd1, 8'h10);

        // Error capture and sticky bits
        bus_write(2'd2, 8'h71);
        idle(2);
        rd_chk("ctrl_readback", 2'd2, 8'h71);
        capture(8'h3C, 3'b100);
        rd_chk("errstat_stop", 2'd3, 8'h14);
        chk("irq_err", 8'(irq), 8'h01);
        bus_write(2'd3, 8'h04);
        rd_chk("errstat_tag_only", 2'd3, 8'h10);
        rd_chk("data_3c", 2'd0, 8'h3C);
        rd_chk("errstat_empty", 2'd3, 8'h00);
        rd_chk("data_when_empty", 2'd0, 8'h00);

        // Disabled receiver ignores frames
        bus_write(2'd2, 8'h70);
        idle(2);
        chk("enable_off", 8'(rx_enable), 8'h00);
        capture(8'h55, 3'b001);
        rd_chk("status_disabled", 2'd1, 8'h10);
        rd_chk("errstat_disabled", 2'd3, 8'h00);

        // Set wins over same-cycle W1C
        bus_write(2'd2, 8'h71);
        idle(2);
        @(negedge clk);
        rx_data = 8'h66; rx_error = 3'b010; rx_done = 1'b1;
        bus_sel = 1'b1; bus_we = 1'b1; bus_addr = 2'd3; bus_wdata = 8'h02;
        @(negedge clk);
        bus_sel = 1'b0; bus_we = 1'b0;
        idle(2);
        rx_done = 1'b0; rx_error = 3'b000;
        rd_chk("errstat_set_wins", 2'd3, 8'h12);
        bus_write(2'd3, 8'h0F);
        rd_chk("data_66", 2'd0, 8'h66);
        rd_chk("errstat_final", 2'd3, 8'h00);

        // Asynchronous reset mid-frame with three bytes buffered
        bus_write(2'd2, 8'h31);
        idle(2);
        @(negedge clk) rx_active = 1'b1;
        capture(8'h01, 3'b000);
        capture(8'h02, 3'b000);
        capture(8'h03, 3'b001);
        rd_chk("status_three", 2'd1, 8'h43);
        chk("baud_before_rst", 8'(cfg_baud_rate), 8'h02);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_baud", 8'(cfg_baud_rate), 8'h00);
        chk("arst_parity", 8'(cfg_parity_type), 8'h00);
        chk("arst_enable", 8'(rx_enable), 8'h01);
        chk("arst_irq", 8'(irq), 8'h00);
        chk("arst_rdata", bus_rdata, 8'h00);
        @(negedge clk);
        rx_active = 1'b0;
        reset = 1'b1;
        rd_chk("status_post_rst", 2'd1, 8'h10);
        rd_chk("errstat_post_rst", 2'd3, 8'h00);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
